// File: rtl/rr_enc8to3_pkg.sv
// Shared constants, FSM encoding and helpers for the round-robin 8-to-3 encoder.
package rr_enc8to3_pkg;

  localparam int NREQ = 8;
  localparam int IDXW = 3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Bit 0 is the leftmost position, matching the decoder's MSB-first ordering.
  function automatic logic [0:NREQ-1] onehot(input logic [IDXW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_enc8to3_pri_enc8.sv
// Combinational 8-to-3 priority encoder: the lowest set index wins; any_o flags a hit.
import rr_enc8to3_pkg::*;

module pri_enc8 (
  input  logic [0:NREQ-1] req_i,
  output logic [IDXW-1:0] idx_o,
  output logic            any_o
);

  // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    idx_o = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDXW'(i);
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/rr_enc8to3.sv
// Round-robin arbiter: grants one of 8 requesters and holds the grant until Done,
// En drop or timeout; the search starts one past the last released owner.
import rr_enc8to3_pkg::*;

module rr_enc8to3 #(
  parameter int TIMEOUT_CYC = 15,
  parameter int CNTW        = 4
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            en_i,
  input  logic [0:NREQ-1] req_i,
  input  logic            done_i,
  output logic [IDXW-1:0] idx_o,
  output logic [0:NREQ-1] grant_o,
  output logic            valid_o,
  output logic            timeout_o
);

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT_CYC - 1);

  logic [0:0]      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [0:NREQ-1] grant_q, grant_d;
  logic            timeout_q, timeout_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [0:NREQ-1] req_rot;
  logic [IDXW-1:0] enc_idx;
  logic            enc_any;
  logic [IDXW-1:0] win_idx;

  // Rotate so the pointer position lands at bit 0, the encoder's top priority.
  always_comb begin
    for (int j = 0; j < NREQ; j++) begin
      req_rot[j] = req_i[IDXW'(ptr_q + IDXW'(j))];
    end
  end

  pri_enc8 u_pri_enc8 (
    .req_i (req_rot),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  assign win_idx = ptr_q + enc_idx;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (en_i && enc_any) begin
        state_d = ST_GRANT;
        idx_d   = win_idx;
        grant_d = onehot(win_idx);
        cnt_d   = '0;
      end
    end else begin
      // Release priority: En drop keeps the pointer, Done beats a coincident timeout.
      if (!en_i) begin
        state_d = ST_IDLE;
        grant_d = '0;
      end else if (done_i) begin
        state_d = ST_IDLE;
        grant_d = '0;
        ptr_d   = idx_q + IDXW'(1);
      end else if (TIMEOUT_CYC != 0 && cnt_q == CNT_LAST) begin
        state_d   = ST_IDLE;
        grant_d   = '0;
        ptr_d     = idx_q + IDXW'(1);
        timeout_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNTW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      grant_q   <= '0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      grant_q   <= grant_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign idx_o     = idx_q;
  assign grant_o   = grant_q;
  assign valid_o   = (state_q == ST_GRANT);
  assign timeout_o = timeout_q;

endmodule
